// File: rtl/spi_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_fifo (+ spi_slave_fifo_buf)
// Brief    : SPI slave, configurable width/mode, RX/TX word FIFOs, sticky errors
// Revision : 1.0
// ============================================================================

module spi_slave_fifo_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                         Clk_i,
  input  logic                         Rst_i,
  input  logic                         Push_i,
  input  logic [DW-1:0]                Data_i,
  input  logic                         Pop_i,
  output logic [DW-1:0]                Data_o,
  output logic                         Full_o,
  output logic                         Empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   Level_o
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH+1);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [c_aw-1:0] r_wr;
  logic [c_aw-1:0] r_rd;
  logic [c_lw-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push  = Push_i & (~Full_o | Pop_i);
  assign w_pop   = Pop_i & ~Empty_o;
  assign Full_o  = (r_cnt == c_lw'(DEPTH));
  assign Empty_o = (r_cnt == '0);
  assign Level_o = r_cnt;
  assign Data_o  = Empty_o ? '0 : r_mem[r_rd];

  always_ff @(posedge Clk_i) begin
    if (w_push) r_mem[r_wr] <= Data_i;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_lw'(1);
        2'b01:   r_cnt <= r_cnt - c_lw'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module spi_slave_fifo #(
  parameter int ID    = 0,
  parameter int NSS   = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       Clk_i,
  input  logic                       Rst_i,
  input  logic                       Sck_i,
  input  logic                       Mosi_i,
  input  logic [NSS-1:0]             Ss_i,
  output logic                       Miso_o,
  input  logic [1:0]                 Mode_i,
  input  logic [DW-1:0]              TxData_i,
  input  logic                       TxValid_i,
  output logic                       TxReady_o,
  output logic [DW-1:0]              RxData_o,
  output logic                       RxValid_o,
  input  logic                       RxReady_i,
  output logic [$clog2(DEPTH+1)-1:0] RxLevel_o,
  output logic                       Busy_o,
  output logic [2:0]                 Err_o,
  input  logic                       ErrClr_i
);
  localparam int c_lw = $clog2(DEPTH+1);
  localparam int c_cw = $clog2(DW+1);
  localparam logic [c_cw-1:0] c_word = c_cw'(DW);

  logic [1:0]      r_sck_s, r_mosi_s, r_ss_s, r_settle, r_mode;
  logic            r_sck_d, r_ss_d, r_armed, r_skip, r_und_pend;
  logic [c_cw-1:0] r_bitcnt;
  logic [DW-1:0]   r_rx_sr, r_tx_sr;
  logic [2:0]      r_err;

  logic w_ss, w_sck, w_active, w_rise, w_fall, w_edge, w_lead, w_trail;
  logic w_sample, w_shift, w_done, w_tx_pop, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_rx_pop, w_ovf, w_und, w_abort;
  logic [DW-1:0]   w_tx_head;
  logic [c_lw-1:0] w_unused_tx_level;
  logic [NSS-1:0]  w_unused_ss;

  assign w_unused_ss = Ss_i;
  assign w_ss  = r_ss_s[1];
  assign w_sck = r_sck_s[1];

  // After reset the selects are only trusted once a synced low has been seen
  assign w_active = r_armed & w_ss & r_ss_d;
  assign w_rise   = r_armed & w_ss & ~r_ss_d;
  assign w_fall   = r_armed & ~w_ss & r_ss_d;
  assign w_edge   = w_sck ^ r_sck_d;
  assign w_lead   = w_edge & (w_sck != r_mode[1]);
  assign w_trail  = w_edge & (w_sck == r_mode[1]);
  assign w_sample = w_active & (r_mode[0] ? w_trail : w_lead);
  assign w_shift  = w_active & (r_mode[0] ? w_lead : w_trail);
  assign w_done   = (r_bitcnt == c_word);

  assign w_tx_pop = (w_rise | w_done) & ~w_tx_empty;
  assign w_rx_pop = RxReady_i & RxValid_o;
  assign w_ovf    = w_done & w_rx_full & ~w_rx_pop;
  // An empty FIFO at word end only counts as underrun if the master keeps clocking
  assign w_und    = (w_rise & w_tx_empty) | (w_sample & r_und_pend);
  assign w_abort  = w_fall & (r_bitcnt != '0) & (r_bitcnt < c_word);

  spi_slave_fifo_buf #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Push_i(TxValid_i), .Data_i(TxData_i), .Pop_i(w_tx_pop),
    .Data_o(w_tx_head), .Full_o(w_tx_full), .Empty_o(w_tx_empty), .Level_o(w_unused_tx_level)
  );

  spi_slave_fifo_buf #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Push_i(w_done), .Data_i(r_rx_sr), .Pop_i(w_rx_pop),
    .Data_o(RxData_o), .Full_o(w_rx_full), .Empty_o(w_rx_empty), .Level_o(RxLevel_o)
  );

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_sck_s <= '0; r_mosi_s <= '0; r_ss_s <= '0;
      r_sck_d <= 1'b0; r_ss_d <= 1'b0;
      r_settle <= '0; r_armed <= 1'b0; r_mode <= '0;
      r_bitcnt <= '0; r_rx_sr <= '0; r_tx_sr <= '0;
      r_skip <= 1'b0; r_und_pend <= 1'b0; r_err <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[0], Sck_i};
      r_mosi_s <= {r_mosi_s[0], Mosi_i};
      r_ss_s   <= {r_ss_s[0], Ss_i[ID]};
      r_sck_d  <= w_sck;
      r_ss_d   <= w_ss;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      else if (!w_ss)       r_armed  <= 1'b1;

      if (w_rise) begin
        r_mode     <= Mode_i;
        r_bitcnt   <= '0;
        r_skip     <= Mode_i[0];
        r_und_pend <= 1'b0;
        r_tx_sr    <= w_tx_empty ? '0 : w_tx_head;
      end else if (w_done) begin
        // The freshly loaded MSB must survive the next shift edge in either phase
        r_bitcnt   <= '0;
        r_skip     <= 1'b1;
        r_und_pend <= w_tx_empty;
        r_tx_sr    <= w_tx_empty ? '0 : w_tx_head;
      end else if (w_fall) begin
        r_bitcnt   <= '0;
        r_und_pend <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_sr    <= {r_rx_sr[DW-2:0], r_mosi_s[1]};
          r_bitcnt   <= r_bitcnt + 1'b1;
          r_und_pend <= 1'b0;
        end
        if (w_shift) begin
          if (r_skip) r_skip  <= 1'b0;
          else        r_tx_sr <= {r_tx_sr[DW-2:0], 1'b0};
        end
      end

      r_err <= (ErrClr_i ? 3'b000 : r_err) | {w_abort, w_und, w_ovf};
    end
  end

  assign Miso_o    = Ss_i[ID] ? r_tx_sr[DW-1] : 1'bz;
  assign TxReady_o = ~w_tx_full;
  assign RxValid_o = ~w_rx_empty;
  assign Busy_o    = w_ss;
  assign Err_o     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_fifo
// Brief    : Scoreboard bench acting as SPI master and host for spi_slave_fifo
// Revision : 1.0
// ============================================================================
module tb_spi_slave_fifo;
  localparam int ID = 0, NSS = 2, DW = 8, DEPTH = 4, LW = $clog2(DEPTH+1), HALF = 8;

  logic           clk = 1'b0, rst = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic [NSS-1:0] ss = '0;
  wire            miso;
  logic [1:0]     mode = 2'b00;
  logic [DW-1:0]  tx_data = '0;
  logic           tx_valid = 1'b0, rx_ready = 1'b0, err_clr = 1'b0;
  logic           tx_ready, rx_valid, busy;
  logic [DW-1:0]  rx_data;
  logic [LW-1:0]  rx_level;
  logic [2:0]     err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rx_q[$];
  logic [31:0] miso_q[$];
  logic [DW-1:0] got;

  spi_slave_fifo #(.ID(ID), .NSS(NSS), .DW(DW), .DEPTH(DEPTH)) dut (
    .Clk_i(clk), .Rst_i(rst), .Sck_i(sck), .Mosi_i(mosi), .Ss_i(ss), .Miso_o(miso),
    .Mode_i(mode), .TxData_i(tx_data), .TxValid_i(tx_valid), .TxReady_o(tx_ready),
    .RxData_o(rx_data), .RxValid_o(rx_valid), .RxReady_i(rx_ready), .RxLevel_o(rx_level),
    .Busy_o(busy), .Err_o(err), .ErrClr_i(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [DW-1:0] d);
    tx_data = d; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    miso_q.push_back(32'(d));
  endtask

  task automatic clear_err();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_txready", 32'(tx_ready), 32'd1);
    check_val("rst_rxvalid", 32'(rx_valid), 32'd0);
    check_val("rst_rxlevel", 32'(rx_level), 32'd0);
    check_val("rst_busy",    32'(busy),     32'd0);
    check_val("rst_rxdata",  32'(rx_data),  32'd0);
    check_val("rst_err",     32'(err),      32'd0);
  endtask

  // Master side of one transfer; MISO captured on the master's sample edge
  task automatic xfer(input logic [1:0] m, input logic [DW-1:0] w, input int nbits,
                      input bit keep_ss, output logic [DW-1:0] rcv);
    mode = m; sck = m[1];
    tick(4);
    ss[ID] = 1'b1;
    tick(HALF);
    rcv = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = w[DW-1-i];
        tick(HALF);
        sck = ~m[1]; rcv = {rcv[DW-2:0], miso};
        tick(HALF);
        sck = m[1];
      end else begin
        sck = ~m[1]; mosi = w[DW-1-i];
        tick(HALF);
        sck = m[1]; rcv = {rcv[DW-2:0], miso};
        tick(HALF);
      end
    end
    if (!keep_ss) begin
      tick(HALF);
      ss[ID] = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic xfer_chk(input logic [1:0] m, input logic [DW-1:0] w, input bit accept);
    logic [DW-1:0] r;
    logic [31:0]   e;
    if (accept) rx_q.push_back(32'(w));
    xfer(m, w, DW, 1'b0, r);
    e = (miso_q.size() > 0) ? miso_q.pop_front() : 32'hDEAD_BEEF;
    check_val($sformatf("miso_m%0d", m), 32'(r), e);
  endtask

  task automatic drain_rx();
    logic [31:0] e;
    for (int i = 0; i < 2*DEPTH; i++) begin
      if (!rx_valid) break;
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
      check_val("rx_data", 32'(rx_data), e);
      rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
    end
    check_val("rx_missing", 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    tick(3);
    check_reset_outputs();
    rst = 1'b0;
    tick(6);

    // Mode 0 basic exchange
    push_tx(8'h3C);
    xfer_chk(2'b00, 8'hA5, 1'b1);
    check_val("m0_level", 32'(rx_level), 32'd1);
    drain_rx();
    check_val("m0_err", 32'(err), 32'd0);

    // Remaining modes
    for (int m = 1; m < 4; m++) begin
      push_tx(8'h7E);
      xfer_chk(2'(m), 8'h81, 1'b1);
      drain_rx();
      check_val("mode_err", 32'(err), 32'd0);
    end

    // RX overflow: five words, no host pops, TX empty throughout
    for (int i = 0; i < 5; i++) begin
      miso_q.push_back(32'h0);
      xfer_chk(2'b00, 8'(8'h11 * (i + 1)), i < DEPTH);
    end
    check_val("ovf_level", 32'(rx_level), 32'(DEPTH));
    check_val("ovf_err", 32'(err), 32'b011);
    drain_rx();
    clear_err();
    check_val("clr_err", 32'(err), 32'd0);

    // TX underrun on an empty FIFO at select
    miso_q.push_back(32'h0);
    xfer_chk(2'b01, 8'h66, 1'b1);
    check_val("und_err", 32'(err), 32'b010);
    drain_rx();
    clear_err();
    check_val("und_clr", 32'(err), 32'd0);

    // Abort after 3 bits, then a clean word
    push_tx(8'h5A);
    xfer(2'b00, 8'hF0, 3, 1'b0, got);
    void'(miso_q.pop_front());
    tick(4);
    check_val("abort_level", 32'(rx_level), 32'd0);
    check_val("abort_err", 32'(err), 32'b100);
    push_tx(8'hC3);
    xfer_chk(2'b00, 8'h55, 1'b1);
    drain_rx();
    check_val("abort_sticky", 32'(err), 32'b100);

    // Reset in the middle of a word
    push_tx(8'h99);
    push_tx(8'h12);
    xfer(2'b11, 8'hAA, 4, 1'b1, got);
    void'(miso_q.pop_front());
    void'(miso_q.pop_front());
    check_val("busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs();
    rst = 1'b0;
    tick(2);
    ss[ID] = 1'b0;
    tick(8);
    push_tx(8'h3C);
    xfer_chk(2'b11, 8'hA5, 1'b1);
    drain_rx();
    check_val("post_rst_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
